// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - word-granular memory-to-memory DMA engine with CPU register window
module dma_copy_engine #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] REG_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              breq,
    input  logic              bgnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              eop
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] src_q, dst_q, addr_q;
    logic [DATA_W-1:0] len_q, buf_q;
    logic              done_q, breq_q, re_q, we_q, eop_q;

    logic       in_win;
    logic [1:0] sel;
    logic       words_nz, last_word, busy;

    assign in_win    = (cpu_addr[ADDR_W-1:4] == REG_BASE[ADDR_W-1:4]) && (cpu_addr[1:0] == 2'b00);
    assign sel       = cpu_addr[3:2];
    assign words_nz  = |len_q[DATA_W-1:2];
    assign last_word = (len_q[DATA_W-1:2] == (DATA_W-2)'(1));
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        cpu_rdata = '0;
        if (in_win) begin
            case (sel)
                2'd0:    cpu_rdata = {{(DATA_W-ADDR_W){1'b0}}, src_q};
                2'd1:    cpu_rdata = {{(DATA_W-ADDR_W){1'b0}}, dst_q};
                2'd2:    cpu_rdata = len_q;
                default: cpu_rdata = {{(DATA_W-2){1'b0}}, done_q, busy};
            endcase
        end
    end

    assign breq      = breq_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = we_q ? buf_q : '0;
    assign eop       = eop_q;

    // Outputs are registered alongside the state so they describe the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            breq_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            breq_q <= 1'b0;
            re_q   <= 1'b0;
            we_q   <= 1'b0;
            eop_q  <= 1'b0;
            addr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_we && in_win) begin
                        case (sel)
                            2'd0: src_q <= {cpu_wdata[ADDR_W-1:2], 2'b00};
                            2'd1: dst_q <= {cpu_wdata[ADDR_W-1:2], 2'b00};
                            2'd2: len_q <= cpu_wdata;
                            default: begin
                                if (cpu_wdata[0]) begin
                                    done_q <= 1'b0;
                                    if (words_nz) begin
                                        state_q <= S_REQ;
                                        breq_q  <= 1'b1;
                                    end else begin
                                        state_q <= S_DONE;
                                        eop_q   <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    breq_q <= 1'b1;
                    if (bgnt) begin
                        state_q <= S_RD;
                        re_q    <= 1'b1;
                        addr_q  <= src_q;
                    end
                end
                S_RD: begin
                    breq_q  <= 1'b1;
                    state_q <= S_CAP;
                end
                S_CAP: begin
                    breq_q  <= 1'b1;
                    buf_q   <= mem_rdata;
                    state_q <= S_WR;
                    we_q    <= 1'b1;
                    addr_q  <= dst_q;
                end
                S_WR: begin
                    src_q <= src_q + ADDR_W'(4);
                    dst_q <= dst_q + ADDR_W'(4);
                    len_q <= len_q - DATA_W'(4);
                    if (last_word) begin
                        state_q <= S_DONE;
                        eop_q   <= 1'b1;
                    end else begin
                        // Grant is only re-checked here, between words.
                        breq_q <= 1'b1;
                        if (bgnt) begin
                            state_q <= S_RD;
                            re_q    <= 1'b1;
                            addr_q  <= src_q + ADDR_W'(4);
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - randomized bench for dma_copy_engine against a schedule/memory model
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;
    logic        breq;
    logic        bgnt;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        eop;

    dma_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .breq      (breq),
        .bgnt      (bgnt),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .eop       (eop)
    );

    always #5 clk = ~clk;

    logic [31:0] sram     [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem  [64];
    logic        do_init;

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 64; i++) sram[i] <= init_mem[i];
        end else if (mem_we) begin
            sram[mem_addr[7:2]] <= mem_wdata;
        end
        if (mem_re) mem_rdata <= sram[mem_addr[7:2]];
    end

    int          checks = 0;
    int          failures = 0;
    bit          gnt [512];
    int          re_cyc [64];
    logic [31:0] wdat [64];
    int          obs_eop_c;
    int          eop_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic sync_mem();
        for (int i = 0; i < 64; i++) init_mem[i] = ref_mem[i];
        @(negedge clk);
        do_init = 1'b1;
        @(negedge clk);
        do_init = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        @(negedge clk);
        cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        cpu_we   = 1'b0;
        cpu_addr = a;
        #1;
        chk(name, cpu_rdata, exp);
    endtask

    task automatic fill_gnt(input int pct);
        for (int i = 0; i < 512; i++) gnt[i] = ($urandom_range(0, 99) < pct);
        for (int i = 480; i < 512; i++) gnt[i] = 1'b1;
    endtask

    task automatic chk_mem(input string name);
        for (int i = 0; i < 64; i++) chk(name, sram[i], ref_mem[i]);
    endtask

    // mode 0: plain copy, 1: register/start writes while busy, 2: reset during WR of word 1
    task automatic run(input int src, input int dst, input int len, input int mode);
        int          n, e, eop_c, kmax, last_busy;
        logic [31:0] tmp [64];
        logic        x_re, x_we, x_breq, x_eop;
        logic [7:0]  x_addr;
        logic [31:0] x_wd;
        n = (len >> 2);
        cpu_write(8'hF0, 32'(src));
        cpu_write(8'hF4, 32'(dst));
        cpu_write(8'hF8, 32'(len));
        e = 1;
        for (int k = 0; k < n; k++) begin
            while (!gnt[e]) e++;
            re_cyc[k] = e;
            e += 3;
        end
        eop_c     = (n == 0) ? 0 : re_cyc[n-1] + 3;
        last_busy = (n == 0) ? -1 : re_cyc[n-1] + 2;
        kmax      = (mode == 2) ? 1 : n;
        for (int i = 0; i < 64; i++) tmp[i] = ref_mem[i];
        for (int k = 0; k < n; k++) begin
            wdat[k] = tmp[((src >> 2) + k) % 64];
            tmp[((dst >> 2) + k) % 64] = wdat[k];
            if (k < kmax) ref_mem[((dst >> 2) + k) % 64] = wdat[k];
        end
        @(negedge clk);
        bgnt      = gnt[0];
        cpu_addr  = 8'hFC;
        cpu_wdata = 32'd1;
        cpu_we    = 1'b1;
        obs_eop_c = -1;
        eop_cnt   = 0;
        for (int c = 0; c <= eop_c + 3; c++) begin
            @(negedge clk);
            x_re = 1'b0; x_we = 1'b0; x_addr = 8'h00; x_wd = 32'h0;
            for (int k = 0; k < n; k++) begin
                if (re_cyc[k] == c) begin
                    x_re   = 1'b1;
                    x_addr = 8'((src + 4 * k) % 256);
                end
                if (re_cyc[k] + 2 == c) begin
                    x_we   = 1'b1;
                    x_addr = 8'((dst + 4 * k) % 256);
                    x_wd   = wdat[k];
                end
            end
            x_breq = (c <= last_busy);
            x_eop  = (c == eop_c);
            chk("breq", 32'(breq), 32'(x_breq));
            chk("mem_re", 32'(mem_re), 32'(x_re));
            chk("mem_we", 32'(mem_we), 32'(x_we));
            chk("mem_addr", 32'(mem_addr), 32'(x_addr));
            chk("mem_wdata", mem_wdata, x_wd);
            chk("eop", 32'(eop), 32'(x_eop));
            if (eop) begin
                eop_cnt++;
                if (obs_eop_c < 0) obs_eop_c = c;
            end
            if (cpu_addr == 8'hFC) chk("ctrl_live", cpu_rdata, (c <= eop_c) ? 32'd1 : 32'd2);
            if (mode == 2 && c == 6) begin
                rst = 1'b1;
                #1;
                chk("rst_breq", 32'(breq), 32'd0);
                chk("rst_re", 32'(mem_re), 32'd0);
                chk("rst_we", 32'(mem_we), 32'd0);
                chk("rst_eop", 32'(eop), 32'd0);
                chk("rst_addr", 32'(mem_addr), 32'd0);
                break;
            end
            bgnt      = gnt[c+1];
            cpu_we    = 1'b0;
            cpu_addr  = 8'hFC;
            cpu_wdata = 32'd1;
            if (mode == 1) begin
                if (c == 3) begin
                    cpu_addr = 8'hF0; cpu_wdata = 32'd0; cpu_we = 1'b1;
                end else if (c == 4 || c == eop_c) begin
                    cpu_we = 1'b1;
                end
            end
        end
        cpu_we = 1'b0;
        if (mode == 2) begin
            @(negedge clk);
            rst  = 1'b0;
            bgnt = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("post_rst_eop", 32'(eop), 32'd0);
                chk("post_rst_breq", 32'(breq), 32'd0);
            end
            cpu_read("post_rst_ctrl", 8'hFC, 32'd0);
            cpu_read("post_rst_src", 8'hF0, 32'd0);
            cpu_read("post_rst_len", 8'hF8, 32'd0);
        end else begin
            cpu_read("end_ctrl", 8'hFC, 32'd2);
            cpu_read("end_src", 8'hF0, 32'((src + 4 * n) % 256));
            cpu_read("end_dst", 8'hF4, 32'((dst + 4 * n) % 256));
            cpu_read("end_len", 8'hF8, 32'(len - 4 * n));
            chk("eop_count", 32'(eop_cnt), 32'd1);
        end
        chk_mem("mem");
    endtask

    initial begin
        rst = 1'b1; cpu_addr = 8'h00; cpu_wdata = 32'h0; cpu_we = 1'b0;
        bgnt = 1'b0; do_init = 1'b0;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("reset_breq", 32'(breq), 32'd0);
        chk("reset_eop", 32'(eop), 32'd0);
        rst = 1'b0;
        sync_mem();
        chk("idle_re", 32'(mem_re), 32'd0);
        chk("idle_we", 32'(mem_we), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        cpu_read("reset_src", 8'hF0, 32'd0);
        cpu_read("reset_dst", 8'hF4, 32'd0);
        cpu_read("reset_len", 8'hF8, 32'd0);
        cpu_read("reset_ctrl", 8'hFC, 32'd0);
        cpu_read("outside_window", 8'h10, 32'd0);

        // Basic copy: bytes 128..135 = 1..8 to 192
        ref_mem[32] = 32'h04030201;
        ref_mem[33] = 32'h08070605;
        sync_mem();
        fill_gnt(100);
        run(128, 192, 8, 0);
        chk("basic_eop_cycle", 32'(obs_eop_c), 32'd7);
        chk("basic_w0", sram[48], 32'h04030201);
        chk("basic_w1", sram[49], 32'h08070605);

        // Zero word count
        run(16, 32, 3, 0);
        chk("len3_eop_cycle", 32'(obs_eop_c), 32'd0);

        // Grant stall of 5 cycles, then grant dropped around word 1
        fill_gnt(100);
        for (int i = 1; i <= 5; i++) gnt[i] = 1'b0;
        gnt[11] = 1'b0;
        gnt[12] = 1'b0;
        run(40, 100, 12, 0);
        chk("stall_eop_cycle", 32'(obs_eop_c), 32'd16);

        // Writes while busy and start during DONE
        fill_gnt(70);
        run(8, 120, 16, 1);

        // Address wrap
        ref_mem[63] = 32'hCAFE0063;
        ref_mem[0]  = 32'hCAFE0000;
        sync_mem();
        fill_gnt(100);
        run(252, 64, 8, 0);
        chk("wrap_w0", sram[16], 32'hCAFE0063);
        chk("wrap_w1", sram[17], 32'hCAFE0000);

        // Reset during WR of word 1
        ref_mem[2]  = 32'h11111111;
        ref_mem[3]  = 32'h22222222;
        ref_mem[50] = 32'hAAAAAAAA;
        ref_mem[51] = 32'hBBBBBBBB;
        sync_mem();
        fill_gnt(100);
        run(8, 200, 12, 2);
        chk("rst_kept_w0", sram[50], 32'h11111111);
        chk("rst_unwritten_w1", sram[51], 32'hBBBBBBBB);
        fill_gnt(60);
        run(8, 200, 12, 0);

        for (int t = 0; t < 8; t++) begin
            int s, d, l;
            s = $urandom_range(0, 63) * 4;
            d = $urandom_range(0, 63) * 4;
            l = $urandom_range(0, 40);
            fill_gnt($urandom_range(40, 100));
            run(s, d, l, (l >= 8 && t[0]) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Word-granular memory-to-memory DMA engine that sits between the CPU and the shared SRAM port. The CPU programs source, destination and length through a small register window, then writes a start bit. The engine requests the SRAM bus, copies 32-bit words from source to destination, releases the bus, and pulses `eop` to report completion.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of the CPU and SRAM buses.
- `DATA_W`, 32: word width.
- `REG_BASE`, 8'hF0: byte address of the register window, 4 registers at +0/+4/+8/+12.

Ports:
- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr`  in  ADDR_W  CPU byte address, decoded against the register window.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_we`  in  1  CPU write strobe.
- `cpu_rdata`  out  DATA_W  combinational register readback; 0 outside the window.
- `breq`  out  1  SRAM bus request.
- `bgnt`  in  1  SRAM bus grant from the arbiter.
- `mem_addr`  out  ADDR_W  SRAM byte address (word-aligned, bits[1:0]=0).
- `mem_re`  out  1  SRAM read strobe; `mem_rdata` is valid the cycle after.
- `mem_we`  out  1  SRAM write strobe; written at the rising edge.
- `mem_wdata`  out  DATA_W  SRAM write data.
- `mem_rdata`  in  DATA_W  SRAM read data, one-cycle latency.
- `eop`  out  1  end-of-process pulse, one cycle.

## Operation
- Registers:
  - SRC (+0) and DST (+4) are byte addresses. Bits[1:0] are forced to 0 on write.
  - LEN (+8) is a byte count. Bits[1:0] are ignored, so word count = LEN>>2.
  - CTRL (+12) write: bit0=1 starts a transfer. CTRL read: bit0=busy, bit1=done.
- SRC, DST and LEN are working registers. They advance during the transfer, and readback shows live values.
- Register and CTRL writes while busy are ignored entirely.
- Starting a transfer clears done.
- FSM states: IDLE, REQ, RD, CAP, WR, DONE.
  - IDLE, start with LEN>>2 != 0: go to REQ.
  - IDLE, start with LEN>>2 == 0: go straight to DONE. No bus request, no memory access.
  - REQ: `breq`=1. Go to RD on the edge where `bgnt`=1; otherwise stay.
  - RD: `mem_addr`=SRC, `mem_re`=1. Go to CAP.
  - CAP: latch `mem_rdata` into the word buffer. Go to WR.
  - WR: `mem_addr`=DST, `mem_we`=1, `mem_wdata`=buffer. On the edge, SRC+=4, DST+=4, LEN-=4.
    - If LEN>>2 becomes 0: go to DONE.
    - Else if `bgnt`=1: go to RD.
    - Else: go to REQ.
  - DONE: `eop`=1 for exactly one cycle, set done, go to IDLE.
- `breq`=1 in REQ, RD, CAP and WR; 0 elsewhere.
- The bus is only re-arbitrated at word boundaries. Losing `bgnt` during RD or CAP does not abort the current word.
- Address arithmetic is modulo 2^ADDR_W: SRC/DST wrap from 252 to 0. LEN decrements never go below 0.
- When not driven, `mem_re`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Reset, including mid-transfer:
  - All registers and the buffer go to 0; state goes to IDLE.
  - `breq`, `mem_re`, `mem_we` and `eop` go to 0 immediately.
  - The transfer is abandoned; words already written stay written.

## Timing
- Reset values: every output is 0, and CTRL reads 0.
- Let E0 be the edge that samples the start write. State is REQ after E0.
- With `bgnt` held at 1:
  - RD after E1.
  - Word k (0-based) has RD in cycle after E(1+3k) and WR in cycle after E(3+3k).
  - DONE after E(1+3N); `eop` is high during that one cycle.
- Throughput: 3 cycles per word with no grant stall. Each stall cycle in REQ adds one cycle.
- LEN=0: `eop` is high in the cycle after E0.
- A start written in the same cycle that DONE is active is ignored, because the engine is busy. A start is accepted from IDLE onward.
- `cpu_rdata` is combinational from `cpu_addr` and current register state.

## Test plan
- Basic copy: 8 bytes at 128..135 = 1,2,...,8; SRC=128, DST=192, LEN=8, start, `bgnt`=1.
  - Bytes 192..199 = 1..8.
  - `eop` high exactly in the cycle after E7; `breq` low after.
  - CTRL reads 2 (done, not busy).
- LEN=3 (word count 0): `eop` in the cycle after E0; `mem_re`/`mem_we` never asserted; `breq` never asserted.
- Grant stall and preemption, 12-byte copy:
  - Hold `bgnt`=0 for 5 cycles: `breq` stays 1, state stays REQ.
  - Drop `bgnt` during word 1's CAP: the WR still occurs, then the engine returns to REQ.
  - Final data is correct and `eop` arrives 3×3 cycles after the first grant plus the stall cycles.
- Write while busy: mid-transfer, write SRC=0 and CTRL=1. Both are ignored; copy destination, length and `eop` count are unchanged (one `eop`).
- Wrap-around: SRC=252, DST=64, LEN=8. Reads hit 252 then 0; words are written to 64 and 68.
- Reset mid-transfer: assert `rst` during the WR of word 1.
  - Outputs drop to 0 asynchronously and no `eop` is produced.
  - Words written before the reset remain.
  - A fresh start after reset completes normally.
